// File: rtl/id_pkg.sv
// Shared decode definitions for the RV64-subset ID stage:
// opcodes, ALU op encodings, control bundle and decode helpers.
package id_pkg;

  localparam int IMM_W = 64;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [6:0] op);
    ctrl_t c;
    c = '0;
    unique case (1'b1)
      (op == OP_R): begin
        c.reg_write = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      (op == OP_IALU): begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      (op == OP_LD): begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_op     = ALU_ADD;
      end
      (op == OP_SD): begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      (op == OP_BEQ): begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_SD) || (op == OP_BEQ);
  endfunction

  function automatic logic [IMM_W-1:0] gen_imm(input logic [31:0] inst);
    logic [IMM_W-1:0] imm;
    logic [6:0]       op;
    op  = inst[6:0];
    imm = '0;
    unique case (1'b1)
      (op == OP_IALU || op == OP_LD):
        imm = {{(IMM_W-12){inst[31]}}, inst[31:20]};
      (op == OP_SD):
        imm = {{(IMM_W-12){inst[31]}}, inst[31:25], inst[11:7]};
      (op == OP_BEQ):
        imm = {{(IMM_W-13){inst[31]}}, inst[31], inst[7],
               inst[30:25], inst[11:8], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_stage_pipelined_if.sv
// Fetch-to-decode handshake bundle.
// Fetch drives the word and PC; decode answers with ready.
interface id_stage_pipelined_if #(
  parameter int XLEN = 64
);
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc;

  modport master (
    output if_valid, if_inst, if_pc,
    input  if_ready
  );

  modport slave (
    input  if_valid, if_inst, if_pc,
    output if_ready
  );
endinterface

// File: rtl/id_regfile.sv
// Two-read / one-write register file, x0 hardwired to zero.
// A same-cycle write to the read address is forwarded (write-first).
module id_regfile
  import id_pkg::*;
#(
  parameter  int XLEN  = 64,
  parameter  int NREGS = 32,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] ra1_i,
  input  logic [RA_W-1:0] ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [RA_W-1:0] wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_ok;

  assign wr_ok = we_i && (wa_i != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = regs_q[ra1_i];
    if (ra1_i == '0)                rd1_o = '0;
    else if (wr_ok && wa_i == ra1_i) rd1_o = wd_i;
  end

  always_comb begin
    rd2_o = regs_q[ra2_i];
    if (ra2_i == '0)                rd2_o = '0;
    else if (wr_ok && wa_i == ra2_i) rd2_o = wd_i;
  end

endmodule

// File: rtl/id_stage_pipelined.sv
// Registered RV64-subset decode stage: control decode, immediates,
// operand read with write-back bypass, load-use stall, ID/EX register.
module id_stage_pipelined
  import id_pkg::*;
#(
  parameter  int XLEN  = 64,
  parameter  int NREGS = 32,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  id_stage_pipelined_if.slave   fetch,
  input  logic                  wb_en,
  input  logic [RA_W-1:0]       wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [RA_W-1:0]       ex_rs1,
  output logic [RA_W-1:0]       ex_rs2,
  output logic [RA_W-1:0]       ex_rd,
  output logic [3:0]            ex_funct,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_reg_write,
  output logic                  ex_illegal
);

  logic [31:0]     inst;
  logic [6:0]      op;
  logic [RA_W-1:0] rs1, rs2, rd;
  logic [XLEN-1:0] rs1_data, rs2_data, imm;
  ctrl_t           ctrl;
  logic            hazard, adv;

  assign inst = fetch.if_inst;
  assign op   = inst[6:0];
  assign rs1  = inst[15 +: RA_W];
  assign rs2  = inst[20 +: RA_W];
  assign rd   = inst[7 +: RA_W];
  assign ctrl = decode_ctrl(op);
  assign imm  = XLEN'(gen_imm(inst));

  id_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (rs1),
    .ra2_i (rs2),
    .rd1_o (rs1_data),
    .rd2_o (rs2_data),
    .we_i  (wb_en),
    .wa_i  (wb_rd),
    .wd_i  (wb_data)
  );

  logic            valid_q;
  logic [XLEN-1:0] pc_q, rs1d_q, rs2d_q, imm_q;
  logic [RA_W-1:0] rs1_q, rs2_q, rd_q;
  logic [3:0]      funct_q;
  ctrl_t           ctrl_q;

  // A load in EX cannot forward its data to a consumer in ID.
  assign hazard = valid_q && ctrl_q.mem_read && (rd_q != '0)
               && fetch.if_valid
               && ((rd_q == rs1) || (uses_rs2(op) && rd_q == rs2));
  assign adv    = !valid_q || ex_ready;

  assign fetch.if_ready = flush || (adv && !hazard);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1d_q  <= '0;
      rs2d_q  <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      funct_q <= '0;
      ctrl_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (adv && hazard) begin
      valid_q <= 1'b0;
    end else if (adv) begin
      valid_q <= fetch.if_valid;
      pc_q    <= fetch.if_pc;
      rs1d_q  <= rs1_data;
      rs2d_q  <= rs2_data;
      imm_q   <= imm;
      rs1_q   <= rs1;
      rs2_q   <= rs2;
      rd_q    <= rd;
      funct_q <= {inst[30], inst[14:12]};
      ctrl_q  <= ctrl;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rs1_data   = rs1d_q;
  assign ex_rs2_data   = rs2d_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_funct      = funct_q;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_branch     = ctrl_q.branch;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: directed scenarios plus a
// randomized run against a behavioural decode/pipeline model.
module tb_id_stage_pipelined;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [63:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b1;

  logic        ex_valid;
  logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;
  logic [1:0]  ex_alu_op;
  logic        ex_alu_src, ex_branch, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_reg_write, ex_illegal;

  int nvec = 0;
  int nerr = 0;

  id_stage_pipelined_if #(.XLEN(64)) fif ();

  id_stage_pipelined dut (
    .clk           (clk),
    .rst           (rst),
    .fetch         (fif),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .flush         (flush),
    .ex_ready      (ex_ready),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_rs1_data   (ex_rs1_data),
    .ex_rs2_data   (ex_rs2_data),
    .ex_imm        (ex_imm),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_funct      (ex_funct),
    .ex_alu_op     (ex_alu_op),
    .ex_alu_src    (ex_alu_src),
    .ex_branch     (ex_branch),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_reg_write  (ex_reg_write),
    .ex_illegal    (ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  funct;
    logic [1:0]  aluop;
    logic        alusrc, branch, mr, mw, m2r, rw, ill;
  } exp_t;

  logic [63:0] mregs [32];
  exp_t        mex;
  logic        mvalid;

  function automatic exp_t dut_now();
    exp_t e;
    e.pc = ex_pc; e.d1 = ex_rs1_data; e.d2 = ex_rs2_data;
    e.imm = ex_imm; e.rs1 = ex_rs1; e.rs2 = ex_rs2; e.rd = ex_rd;
    e.funct = ex_funct; e.aluop = ex_alu_op;
    e.alusrc = ex_alu_src; e.branch = ex_branch;
    e.mr = ex_mem_read; e.mw = ex_mem_write;
    e.m2r = ex_mem_to_reg; e.rw = ex_reg_write; e.ill = ex_illegal;
    return e;
  endfunction

  function automatic logic [63:0] mread(input logic [4:0] r);
    if (r == 0) return 64'd0;
    if (wb_en && wb_rd == r) return wb_data;
    return mregs[r];
  endfunction

  function automatic exp_t mdecode(input logic [31:0] i,
                                   input logic [63:0] pc);
    exp_t e;
    logic [8:0] c;
    logic signed [63:0] s;
    logic [11:0] i12, s12;
    logic [12:0] b13;
    e = '0;
    i12 = i[31:20];
    s12 = {i[31:25], i[11:7]};
    b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    s = 0;
    // {alusrc, m2r, rw, mr, mw, br, aluop[1:0], illegal}
    case (i[6:0])
      7'h33: c = 9'b0_0_1_0_0_0_10_0;
      7'h13: begin c = 9'b1_0_1_0_0_0_10_0; s = $signed(i12); end
      7'h03: begin c = 9'b1_1_1_1_0_0_00_0; s = $signed(i12); end
      7'h23: begin c = 9'b1_0_0_0_1_0_00_0; s = $signed(s12); end
      7'h63: begin c = 9'b0_0_0_0_0_1_01_0; s = $signed(b13); end
      default: c = 9'b0_0_0_0_0_0_00_1;
    endcase
    {e.alusrc, e.m2r, e.rw, e.mr, e.mw, e.branch, e.aluop, e.ill} = c;
    e.imm = s;
    e.pc = pc;
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd = i[11:7];
    e.funct = {i[30], i[14:12]};
    e.d1 = mread(e.rs1);
    e.d2 = mread(e.rs2);
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fif.if_valid = 1'b0;
    wb_en = 1'b0;
    flush = 1'b0;
    ex_ready = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc();
    nvec++;
    if (ex_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_valid: got %b want 0", ex_valid);
    end
    nvec++;
    if (dut_now() !== '0) begin
      nerr++;
      $display("FAIL reset_ex_zero: got %h want 0", dut_now());
    end
    rst = 1'b0;
    cyc();
    fif.if_valid = 1'b1;
    fif.if_inst = 32'h000283B3;
    fif.if_pc = 64'h10;
    cyc();
    nvec++;
    if (ex_valid !== 1'b1 || ex_rs1_data !== 64'd0) begin
      nerr++;
      $display("FAIL reset_read_x5: got v=%b d=%h want v=1 d=0",
               ex_valid, ex_rs1_data);
    end
    idle();
  endtask

  task automatic test_add();
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 64'd9;
    cyc();
    wb_rd = 5'd6; wb_data = 64'd12;
    cyc();
    wb_en = 1'b0;
    fif.if_valid = 1'b1;
    fif.if_inst = 32'h006183B3;
    fif.if_pc = 64'h20;
    cyc();
    nvec++;
    if ({ex_valid, ex_rs1_data, ex_rs2_data, ex_alu_op, ex_reg_write,
         ex_rd} !== {1'b1, 64'd9, 64'd12, 2'b10, 1'b1, 5'd7}) begin
      nerr++;
      $display("FAIL add: got v=%b a=%h b=%h op=%b rw=%b rd=%0d want 1 9 c 10 1 7",
               ex_valid, ex_rs1_data, ex_rs2_data, ex_alu_op,
               ex_reg_write, ex_rd);
    end
    idle();
  endtask

  task automatic test_bypass();
    fif.if_valid = 1'b1;
    fif.if_inst = 32'h006183B3;
    fif.if_pc = 64'h24;
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 64'h55;
    cyc();
    nvec++;
    if (ex_rs1_data !== 64'h55 || ex_rs2_data !== 64'd12) begin
      nerr++;
      $display("FAIL bypass: got a=%h b=%h want 55 c",
               ex_rs1_data, ex_rs2_data);
    end
    idle();
  endtask

  task automatic test_load_use();
    fif.if_valid = 1'b1;
    fif.if_inst = 32'h0081B283;
    fif.if_pc = 64'h40;
    cyc();
    fif.if_inst = 32'h006283B3;
    fif.if_pc = 64'h44;
    #1;
    nvec++;
    if (fif.if_ready !== 1'b0) begin
      nerr++;
      $display("FAIL loaduse_stall_ready: got %b want 0", fif.if_ready);
    end
    cyc();
    nvec++;
    if (ex_valid !== 1'b0) begin
      nerr++;
      $display("FAIL loaduse_bubble: got %b want 0", ex_valid);
    end
    cyc();
    nvec++;
    if (ex_valid !== 1'b1 || ex_pc !== 64'h44 || ex_rs1 !== 5'd5) begin
      nerr++;
      $display("FAIL loaduse_issue: got v=%b pc=%h rs1=%0d want 1 44 5",
               ex_valid, ex_pc, ex_rs1);
    end
    fif.if_inst = 32'h0081B003;
    fif.if_pc = 64'h48;
    cyc();
    fif.if_inst = 32'h006003B3;
    fif.if_pc = 64'h4C;
    #1;
    nvec++;
    if (fif.if_ready !== 1'b1) begin
      nerr++;
      $display("FAIL loadx0_ready: got %b want 1", fif.if_ready);
    end
    cyc();
    nvec++;
    if (ex_valid !== 1'b1 || ex_pc !== 64'h4C) begin
      nerr++;
      $display("FAIL loadx0_nobubble: got v=%b pc=%h want 1 4c",
               ex_valid, ex_pc);
    end
    idle();
  endtask

  task automatic test_imm();
    fif.if_valid = 1'b1;
    fif.if_inst = 32'hFE000EE3;
    fif.if_pc = 64'h60;
    cyc();
    nvec++;
    if (ex_imm !== 64'hFFFF_FFFF_FFFF_FFFC || ex_branch !== 1'b1
        || ex_alu_op !== 2'b01) begin
      nerr++;
      $display("FAIL beq_imm: got imm=%h br=%b op=%b want fffffffffffffffc 1 01",
               ex_imm, ex_branch, ex_alu_op);
    end
    fif.if_inst = 32'h00613823;
    fif.if_pc = 64'h64;
    cyc();
    nvec++;
    if (ex_imm !== 64'd16 || ex_mem_write !== 1'b1
        || ex_reg_write !== 1'b0) begin
      nerr++;
      $display("FAIL sd_imm: got imm=%h mw=%b rw=%b want 10 1 0",
               ex_imm, ex_mem_write, ex_reg_write);
    end
    idle();
  endtask

  task automatic test_backpressure();
    fif.if_valid = 1'b1;
    fif.if_inst = 32'h006183B3;
    fif.if_pc = 64'h100;
    cyc();
    ex_ready = 1'b0;
    fif.if_inst = 32'h00613823;
    fif.if_pc = 64'h104;
    for (int k = 0; k < 3; k++) begin
      #1;
      nvec++;
      if (fif.if_ready !== 1'b0) begin
        nerr++;
        $display("FAIL stall_ready[%0d]: got %b want 0", k, fif.if_ready);
      end
      cyc();
      nvec++;
      if ({ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_rd}
          !== {1'b1, 64'h100, 64'h55, 64'd12, 5'd7}) begin
        nerr++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h a=%h b=%h rd=%0d",
                 k, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_rd);
      end
    end
    flush = 1'b1;
    #1;
    nvec++;
    if (fif.if_ready !== 1'b1) begin
      nerr++;
      $display("FAIL flush_ready: got %b want 1", fif.if_ready);
    end
    cyc();
    nvec++;
    if (ex_valid !== 1'b0) begin
      nerr++;
      $display("FAIL flush_valid: got %b want 0", ex_valid);
    end
    idle();
  endtask

  task automatic test_illegal_x0();
    fif.if_valid = 1'b1;
    fif.if_inst = 32'h0000007F;
    fif.if_pc = 64'h200;
    cyc();
    nvec++;
    if ({ex_illegal, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write,
         ex_mem_to_reg, ex_reg_write, ex_alu_op} !== 9'b1_000000_00) begin
      nerr++;
      $display("FAIL illegal: got ill=%b ctl=%b%b%b%b%b%b op=%b want 1 000000 00",
               ex_illegal, ex_alu_src, ex_branch, ex_mem_read,
               ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_alu_op);
    end
    fif.if_valid = 1'b0;
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hDEAD;
    cyc();
    fif.if_valid = 1'b1;
    fif.if_inst = 32'h000003B3;
    fif.if_pc = 64'h204;
    cyc();
    nvec++;
    if (ex_rs1_data !== 64'd0 || ex_rs2_data !== 64'd0) begin
      nerr++;
      $display("FAIL x0_read: got a=%h b=%h want 0 0",
               ex_rs1_data, ex_rs2_data);
    end
    idle();
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    logic [31:0] i;
    logic [4:0] r1, r2;
    logic haz, adv, exp_rdy, u2;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F};
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int r = 0; r < 32; r++) mregs[r] = 64'd0;
    mex = '0;
    mvalid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      i = $urandom;
      i[6:0] = ops[$urandom_range(0, 5)];
      i[11:7] = 5'($urandom_range(0, 7));
      i[19:15] = 5'($urandom_range(0, 7));
      i[24:20] = 5'($urandom_range(0, 7));
      fif.if_inst = i;
      fif.if_pc = {$urandom, $urandom};
      fif.if_valid = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      wb_en = $urandom_range(0, 1) == 1;
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = {$urandom, $urandom};
      #1;
      r1 = i[19:15];
      r2 = i[24:20];
      u2 = (i[6:0] == 7'h33) || (i[6:0] == 7'h23) || (i[6:0] == 7'h63);
      haz = mvalid && mex.mr && mex.rd != 0 && fif.if_valid
            && (mex.rd == r1 || (u2 && mex.rd == r2));
      adv = !mvalid || ex_ready;
      exp_rdy = flush || (adv && !haz);
      nvec++;
      if (fif.if_ready !== exp_rdy) begin
        nerr++;
        $display("FAIL rand_ready[%0d]: got %b want %b",
                 n, fif.if_ready, exp_rdy);
      end
      if (flush || (adv && haz)) begin
        mvalid = 1'b0;
      end else if (adv) begin
        mex = mdecode(i, fif.if_pc);
        mvalid = fif.if_valid;
      end
      if (wb_en && wb_rd != 0) mregs[wb_rd] = wb_data;
      cyc();
      nvec++;
      if (ex_valid !== mvalid) begin
        nerr++;
        $display("FAIL rand_valid[%0d]: got %b want %b",
                 n, ex_valid, mvalid);
      end
      if (mvalid) begin
        nvec++;
        if (dut_now() !== mex) begin
          nerr++;
          $display("FAIL rand_ex[%0d]: got %h want %h",
                   n, dut_now(), mex);
        end
      end
    end
    fif.if_valid = 1'b1;
    fif.if_inst = 32'h006183B3;
    flush = 1'b0;
    ex_ready = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    nvec++;
    if (ex_valid !== 1'b0) begin
      nerr++;
      $display("FAIL midop_reset: got %b want 0", ex_valid);
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    fif.if_valid = 1'b0;
    fif.if_inst = '0;
    fif.if_pc = '0;
    test_reset();
    test_add();
    test_bypass();
    test_load_use();
    test_imm();
    test_backpressure();
    test_illegal_x0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
